// File: rtl/egg_pkg.sv
// Shared types and constants for the egg timer countdown stages.
package egg_pkg;

  localparam int EGG_W        = 7;
  localparam int EGG_PRESCALE = 16;

  typedef enum logic [1:0] {
    EGG_IDLE   = 2'd0,
    EGG_RUN    = 2'd1,
    EGG_PAUSED = 2'd2,
    EGG_ALARM  = 2'd3
  } egg_state_e;

  // Decrement that stops at zero instead of wrapping.
  function automatic logic [EGG_W-1:0] sat_dec(input logic [EGG_W-1:0] v);
    if (v == 7'd0) begin
      sat_dec = 7'd0;
    end else begin
      sat_dec = v - 7'd1;
    end
  endfunction

endpackage

// File: rtl/egg_prescaler.sv
// Free-running prescaler with enable and clear; wrap strobes on the last count while enabled.
module egg_prescaler #(
  parameter int PRESCALE = 16
) (
  input  logic sysclk,
  input  logic reset,
  input  logic enable,
  input  logic clear,
  output logic wrap
);

  localparam int PW = (PRESCALE > 2) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

  logic [PW-1:0] count_r;

  assign wrap = enable && (count_r == LAST);

  // Prescale counter: clear wins over enable, wraps to zero after LAST.
  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      count_r <= {PW{1'b0}};
    end else if (clear) begin
      count_r <= {PW{1'b0}};
    end else if (enable) begin
      if (wrap) begin
        count_r <= {PW{1'b0}};
      end else begin
        count_r <= count_r + PW'(1);
      end
    end else begin
      count_r <= count_r;
    end
  end

endmodule

// File: rtl/egg_countdown.sv
// Countdown timer: loads egg_timer on a falling selection, counts down in prescaled ticks, raises alarm.
module egg_countdown
  import egg_pkg::*;
#(
  parameter int PRESCALE = EGG_PRESCALE
) (
  input  logic             sysclk,
  input  logic             reset,
  input  logic             selection,
  input  logic [EGG_W-1:0] egg_timer,
  input  logic             pause,
  input  logic             ack,
  output logic [EGG_W-1:0] remaining,
  output logic             running,
  output logic             alarm,
  output logic             done_pulse
);

  egg_state_e       state_r;
  egg_state_e       state_nx_s;
  logic [EGG_W-1:0] rem_nx_s;
  logic             done_nx_s;
  logic             run_nx_s;
  logic             alarm_nx_s;
  logic             sel_q_r;
  logic             start_s;
  logic             presc_en_s;
  logic             wrap_s;

  assign start_s = sel_q_r && !selection;

  // The edge that leaves PAUSED already counts, so resuming neither loses nor adds a tick.
  assign presc_en_s = !start_s && !pause &&
                      ((state_r == EGG_RUN) || (state_r == EGG_PAUSED));

  egg_prescaler #(
    .PRESCALE (PRESCALE)
  ) u_prescaler (
    .sysclk (sysclk),
    .reset  (reset),
    .enable (presc_en_s),
    .clear  (start_s),
    .wrap   (wrap_s)
  );

  // State register, count register, start-edge detector and registered outputs.
  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      state_r    <= EGG_IDLE;
      sel_q_r    <= 1'b1;
      remaining  <= 7'd0;
      running    <= 1'b0;
      alarm      <= 1'b0;
      done_pulse <= 1'b0;
    end else begin
      state_r    <= state_nx_s;
      sel_q_r    <= selection;
      remaining  <= rem_nx_s;
      running    <= run_nx_s;
      alarm      <= alarm_nx_s;
      done_pulse <= done_nx_s;
    end
  end

  // Next state and next count; start beats ack, ack beats pause, pause beats tick.
  always_comb begin
    state_nx_s = state_r;
    rem_nx_s   = remaining;
    done_nx_s  = 1'b0;
    if (start_s) begin
      rem_nx_s = egg_timer;
      if (egg_timer == 7'd0) begin
        state_nx_s = EGG_ALARM;
        done_nx_s  = 1'b1;
      end else begin
        state_nx_s = EGG_RUN;
      end
    end else begin
      case (state_r)
        EGG_IDLE: begin
          state_nx_s = EGG_IDLE;
        end
        EGG_RUN, EGG_PAUSED: begin
          if (pause) begin
            state_nx_s = EGG_PAUSED;
          end else if (wrap_s) begin
            rem_nx_s = sat_dec(remaining);
            if (remaining <= 7'd1) begin
              state_nx_s = EGG_ALARM;
              done_nx_s  = 1'b1;
            end else begin
              state_nx_s = EGG_RUN;
            end
          end else begin
            state_nx_s = EGG_RUN;
          end
        end
        EGG_ALARM: begin
          rem_nx_s = 7'd0;
          if (ack) begin
            state_nx_s = EGG_IDLE;
          end else begin
            state_nx_s = EGG_ALARM;
          end
        end
        default: begin
          state_nx_s = EGG_IDLE;
        end
      endcase
    end
  end

  // Output decode of the next state so the flags change on the same edge as the state.
  always_comb begin
    run_nx_s   = 1'b0;
    alarm_nx_s = 1'b0;
    case (state_nx_s)
      EGG_RUN, EGG_PAUSED: run_nx_s   = 1'b1;
      EGG_ALARM:           alarm_nx_s = 1'b1;
      default: begin
        run_nx_s   = 1'b0;
        alarm_nx_s = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_egg_countdown.sv
// Directed bench for egg_countdown (PRESCALE=4) with an active-cycle-count reference model.
module tb_egg_countdown;

  localparam int P = 4;

  logic       sysclk;
  logic       reset;
  logic       selection;
  logic [6:0] egg_timer;
  logic       pause;
  logic       ack;
  logic [6:0] remaining;
  logic       running;
  logic       alarm;
  logic       done_pulse;

  int checks = 0;
  int passes = 0;

  egg_countdown #(.PRESCALE(P)) dut (
    .sysclk     (sysclk),
    .reset      (reset),
    .selection  (selection),
    .egg_timer  (egg_timer),
    .pause      (pause),
    .ack        (ack),
    .remaining  (remaining),
    .running    (running),
    .alarm      (alarm),
    .done_pulse (done_pulse)
  );

  initial sysclk = 1'b0;
  always #5 sysclk = ~sysclk;

  // Reference model: the count shown is load minus completed ticks, where a tick is P active edges.
  bit m_prev_sel;
  bit m_running;
  bit m_alarm;
  bit m_done;
  int m_load;
  int m_active;
  int m_rem;
  wire m_start = m_prev_sel && !selection;

  always @(posedge sysclk or posedge reset) begin
    if (reset) begin
      m_prev_sel <= 1'b1;
      m_running  <= 1'b0;
      m_alarm    <= 1'b0;
      m_done     <= 1'b0;
      m_load     <= 0;
      m_active   <= 0;
      m_rem      <= 0;
    end else begin
      m_prev_sel <= selection;
      if (m_start) begin
        m_load   <= int'(egg_timer);
        m_active <= 0;
        m_rem    <= int'(egg_timer);
        m_running <= (egg_timer != 7'd0);
        m_alarm   <= (egg_timer == 7'd0);
        m_done    <= (egg_timer == 7'd0);
      end else if (m_alarm) begin
        m_done <= 1'b0;
        if (ack) m_alarm <= 1'b0;
      end else if (m_running && !pause) begin
        m_active <= m_active + 1;
        m_rem    <= m_load - (m_active + 1) / P;
        if (m_load * P == m_active + 1) begin
          m_running <= 1'b0;
          m_alarm   <= 1'b1;
          m_done    <= 1'b1;
        end else begin
          m_done <= 1'b0;
        end
      end else begin
        m_done <= 1'b0;
      end
    end
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
  endtask

  // Every falling edge: all outputs against the model.
  always @(negedge sysclk) begin
    check("model_remaining", int'(remaining), m_rem);
    check("model_running", int'(running), int'(m_running));
    check("model_alarm", int'(alarm), int'(m_alarm));
    check("model_done", int'(done_pulse), int'(m_done));
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge sysclk);
      #1;
    end
  endtask

  // Returns 1ns after the load edge.
  task automatic start(input logic [6:0] val);
    selection = 1'b1;
    cyc(1);
    selection = 1'b0;
    egg_timer = val;
    cyc(1);
  endtask

  task automatic pulse_ack();
    ack = 1'b1;
    cyc(1);
    ack = 1'b0;
  endtask

  initial begin
    reset = 1'b0;
    selection = 1'b1;
    egg_timer = 7'd0;
    pause = 1'b0;
    ack = 1'b0;
    #1 reset = 1'b1;
    cyc(2);
    check("reset_remaining", int'(remaining), 0);
    check("reset_flags", int'({running, alarm, done_pulse}), 0);
    reset = 1'b0;
    cyc(1);
    check("no_start_sel_high", int'(running), 0);

    // Upstream release: selection 1->0 with egg_timer 0->7F.
    selection = 1'b0;
    egg_timer = 7'h7F;
    cyc(1);
    check("load_127", int'(remaining), 127);
    check("load_running", int'(running), 1);
    cyc(3);
    check("hold_127", int'(remaining), 127);
    cyc(1);
    check("first_tick_126", int'(remaining), 126);
    cyc(503);
    check("pre_expiry_1", int'(remaining), 1);
    check("pre_expiry_done", int'(done_pulse), 0);
    cyc(1);
    check("expiry_508_done", int'(done_pulse), 1);
    check("expiry_508_alarm", int'(alarm), 1);
    pulse_ack();
    check("ack_clears_alarm", int'(alarm), 0);

    // Load 3, no pause.
    start(7'd3);
    check("l3_load", int'(remaining), 3);
    cyc(4);
    check("l3_plus4", int'(remaining), 2);
    cyc(4);
    check("l3_plus8", int'(remaining), 1);
    cyc(4);
    check("l3_plus12", int'(remaining), 0);
    check("l3_done", int'(done_pulse), 1);
    cyc(5);
    check("l3_alarm_held", int'(alarm), 1);
    check("l3_done_cleared", int'(done_pulse), 0);
    pulse_ack();
    check("l3_idle", int'({running, alarm}), 0);

    // Load 3, pause for 5 edges mid-count: expiry at load+17.
    start(7'd3);
    cyc(2);
    pause = 1'b1;
    cyc(5);
    check("paused_hold", int'(remaining), 3);
    check("paused_running", int'(running), 1);
    pause = 1'b0;
    cyc(9);
    check("pause_plus16", int'(remaining), 1);
    cyc(1);
    check("pause_plus17_done", int'(done_pulse), 1);
    pulse_ack();

    // Load 0: straight to ALARM.
    start(7'd0);
    check("l0_done", int'(done_pulse), 1);
    check("l0_alarm", int'(alarm), 1);
    check("l0_running", int'(running), 0);

    // Restart plus ack in ALARM: restart wins.
    selection = 1'b1;
    cyc(1);
    selection = 1'b0;
    egg_timer = 7'd2;
    ack = 1'b1;
    cyc(1);
    ack = 1'b0;
    check("restart_alarm", int'(alarm), 0);
    check("restart_running", int'(running), 1);
    check("restart_remaining", int'(remaining), 2);

    // Start while PAUSED with pause held high.
    pause = 1'b1;
    cyc(2);
    selection = 1'b1;
    cyc(1);
    selection = 1'b0;
    egg_timer = 7'd5;
    cyc(3);
    check("paused_reload", int'(remaining), 5);
    pause = 1'b0;
    cyc(25);
    pulse_ack();

    // Reset pulsed at load+6 of a 3-count.
    start(7'd3);
    cyc(6);
    check("pre_reset_rem", int'(remaining), 2);
    reset = 1'b1;
    #1;
    check("async_reset_rem", int'(remaining), 0);
    check("async_reset_flags", int'({running, alarm, done_pulse}), 0);
    selection = 1'b1;
    cyc(2);
    reset = 1'b0;
    cyc(20);
    check("post_reset_idle", int'({running, alarm}), 0);

    cyc(2);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
